// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the register-file write-port arbiter.
// Requester indices double as the grant_src encoding and the `last` value.
package rf_write_arbiter_pkg;
    localparam int   DEF_WIDTH  = 32;
    localparam int   DEF_ADDR_W = 5;
    localparam logic REQ_ALU    = 1'b0;
    localparam logic REQ_MEM    = 1'b1;
    localparam int   ZERO_REG   = 0;
endpackage

// File: rtl/rf_write_arbiter_sat_counter.sv
// Saturating up-counter for stall statistics.
// Latency: count reflects inc one cycle later; no backpressure (always counts when inc=1).
// Holds at all-ones; only rst clears it.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and load writeback.
// Latency: a handshake in cycle N drives WE3/A3/WD3 in cycle N+1.
// Backpressure: loser (or everyone under freeze/rst) sees ready=0 and must hold its request.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [WIDTH-1:0]  alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_data,
    output logic              mem_ready,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [WIDTH-1:0]  WD3,
    output logic              grant_src,
    output logic [CNT_W-1:0]  alu_stall_cnt,
    output logic [CNT_W-1:0]  mem_stall_cnt
);
    logic              last;
    logic              grant_alu;
    logic              grant_mem;
    logic              handshake;
    logic              grant_idx;
    logic [ADDR_W-1:0] grant_addr;
    logic [WIDTH-1:0]  grant_data;

    // Under contention the side that did not win last time gets the port.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!rst && !freeze) begin
            if (alu_valid && mem_valid) begin
                grant_alu = (last == REQ_MEM);
                grant_mem = (last == REQ_ALU);
            end else begin
                grant_alu = alu_valid;
                grant_mem = mem_valid;
            end
        end
    end

    assign alu_ready  = grant_alu;
    assign mem_ready  = grant_mem;
    assign handshake  = grant_alu | grant_mem;
    assign grant_idx  = grant_mem ? REQ_MEM : REQ_ALU;
    assign grant_addr = grant_mem ? mem_addr : alu_addr;
    assign grant_data = grant_mem ? mem_data : alu_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= REQ_MEM;
            WE3       <= 1'b0;
            A3        <= '0;
            WD3       <= '0;
            grant_src <= REQ_ALU;
        end else begin
            // Register 0 writes are consumed but never enabled on the port.
            WE3 <= handshake && (grant_addr != ADDR_W'(ZERO_REG));
            if (handshake) begin
                last      <= grant_idx;
                A3        <= grant_addr;
                WD3       <= grant_data;
                grant_src <= grant_idx;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_alu_stall (
        .clk   (clk),
        .rst   (rst),
        .inc   (alu_valid && !alu_ready),
        .count (alu_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mem_stall (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_valid && !mem_ready),
        .count (mem_stall_cnt)
    );
endmodule
